// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: access encodings, FSM states
// and the alignment rules used both at request acceptance and in the datapath.
package load_store_unit_pkg;

  localparam int XLEN   = 32;
  localparam int BE_LEN = 4;

  typedef enum logic [3:0] {
    LS_N_A = 4'd0,
    L_B    = 4'd1,
    L_BU   = 4'd2,
    L_H    = 4'd3,
    L_HU   = 4'd4,
    L_W    = 4'd5,
    S_B    = 4'd6,
    S_H    = 4'd7,
    S_W    = 4'd8
  } load_store_type_e;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_DONE,
    LSU_ERR
  } lsu_state_e;

  function automatic logic ls_is_store(load_store_type_e t);
    return (t == S_B) || (t == S_H) || (t == S_W);
  endfunction

  function automatic logic ls_misaligned(load_store_type_e t, logic [1:0] addr_lo);
    logic mis;
    case (t)
      L_W, S_W:       mis = (addr_lo != 2'b00);
      L_H, L_HU, S_H: mis = addr_lo[0];
      default:        mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store-data replication and
// load-data extraction with sign/zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  load_store_type_e    ls_type_i,
  input  logic [1:0]          addr_lo_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic [XLEN-1:0]     mem_rdata_i,
  output logic [BE_LEN-1:0]   be_o,
  output logic [XLEN-1:0]     wdata_o,
  output logic [XLEN-1:0]     rdata_o
);

  logic [15:0]        sh;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    sh     = 16'(mem_rdata_i >> {addr_lo_i, 3'b000});
    byte_s = signed'(sh[7:0]);
    half_s = signed'(sh[15:0]);

    case (ls_type_i)
      L_W, S_W:       be_o = 4'b1111;
      L_H, L_HU, S_H: be_o = 4'b0011 << {addr_lo_i[1], 1'b0};
      L_B, L_BU, S_B: be_o = 4'b0001 << addr_lo_i;
      default:        be_o = 4'b0000;
    endcase

    case (ls_type_i)
      S_H:     wdata_o = {2{wdata_i[15:0]}};
      S_B:     wdata_o = {4{wdata_i[7:0]}};
      default: wdata_o = wdata_i;
    endcase

    case (ls_type_i)
      L_B:     rdata_o = XLEN'(byte_s);
      L_BU:    rdata_o = XLEN'(sh[7:0]);
      L_H:     rdata_o = XLEN'(half_s);
      L_HU:    rdata_o = XLEN'(sh[15:0]);
      default: rdata_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: accepts one load/store from the core, runs a req/gnt
// then rvalid bus transaction, and returns formatted load data with stall and error flags.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  input  logic [3:0]        ls_type_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [BE_LEN-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(TIMEOUT_CYCLES - 1);

  load_store_type_e ls_type;
  lsu_state_e       state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic             err_bus_q, err_bus_d;
  load_store_type_e type_q, type_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;

  logic [BE_LEN-1:0] be_fmt;
  logic [XLEN-1:0]   wdata_fmt;
  logic [XLEN-1:0]   rdata_fmt;

  assign ls_type = load_store_type_e'(ls_type_i);

  lsu_align u_align (
    .ls_type_i   (type_q),
    .addr_lo_i   (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .mem_rdata_i (mem_rdata_i),
    .be_o        (be_fmt),
    .wdata_o     (wdata_fmt),
    .rdata_o     (rdata_fmt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= LSU_IDLE;
      cnt_q     <= '0;
      err_bus_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_bus_q <= err_bus_d;
      rdata_q   <= rdata_d;
    end
  end

  // Request operands only matter while REQ/WAIT, so they carry no reset.
  always_ff @(posedge clk) begin
    type_q  <= type_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_bus_d = err_bus_q;
    type_d    = type_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    case (state_q)
      LSU_IDLE: begin
        if (req_valid_i && (ls_type != LS_N_A)) begin
          if (ls_misaligned(ls_type, addr_i[1:0])) begin
            state_d   = LSU_ERR;
            err_bus_d = 1'b0;
          end else begin
            state_d = LSU_REQ;
            cnt_d   = '0;
            type_d  = ls_type;
            addr_d  = addr_i;
            wdata_d = wdata_i;
          end
        end
      end
      LSU_REQ: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (mem_gnt_i) begin
          state_d = LSU_WAIT;
        end else if (cnt_q >= CNT_LAST) begin
          state_d   = LSU_ERR;
          err_bus_d = 1'b1;
        end
      end
      LSU_WAIT: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (mem_rvalid_i) begin
          state_d = LSU_DONE;
          if (!ls_is_store(type_q)) rdata_d = rdata_fmt;
        end else if (cnt_q >= CNT_LAST) begin
          state_d   = LSU_ERR;
          err_bus_d = 1'b1;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      LSU_ERR:  state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // Bus fields are driven only while requesting so they read as zero otherwise.
  always_comb begin
    busy_o      = (state_q != LSU_IDLE);
    done_o      = (state_q == LSU_DONE) || (state_q == LSU_ERR);
    misalign_o  = (state_q == LSU_ERR) && !err_bus_q;
    bus_err_o   = (state_q == LSU_ERR) && err_bus_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (state_q == LSU_REQ) begin
      mem_req_o   = 1'b1;
      mem_we_o    = ls_is_store(type_q);
      mem_addr_o  = {addr_q[XLEN-1:2], 2'b00};
      mem_be_o    = be_fmt;
      mem_wdata_o = wdata_fmt;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vectors plus randomized accesses checked
// against a byte-lane reference model of the access rules.
`timescale 1ns/1ps
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TO = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic [3:0]  ls_type_i = 4'd0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        busy_o, done_o, misalign_o, bus_err_o;
  logic [31:0] rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rdata = '0;

  typedef struct {
    int          lat;
    bit          req_seen;
    bit          stable;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rdata;
    logic        mis;
    logic        berr;
    bit          idle_after;
  } obs_t;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .ls_type_i    (ls_type_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .misalign_o   (misalign_o),
    .bus_err_o    (bus_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: access size in bytes drives every rule.
  function automatic int m_size(load_store_type_e t);
    if (t == L_B || t == L_BU || t == S_B) return 1;
    if (t == L_H || t == L_HU || t == S_H) return 2;
    return 4;
  endfunction

  function automatic bit m_store(load_store_type_e t);
    return t == S_B || t == S_H || t == S_W;
  endfunction

  function automatic bit m_mis(load_store_type_e t, logic [31:0] a);
    return (a % m_size(t)) != 0;
  endfunction

  function automatic logic [3:0] m_be(load_store_type_e t, logic [31:0] a);
    int n = m_size(t);
    int off = ((a % 4) / n) * n;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wd(load_store_type_e t, logic [31:0] wd);
    int n = m_size(t);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(load_store_type_e t, logic [31:0] a, logic [31:0] w);
    int n = m_size(t);
    logic [31:0] mask, v;
    if (n == 4) return w;
    mask = (32'h1 << (8 * n)) - 32'h1;
    v = (w >> (8 * (a % 4))) & mask;
    if ((t == L_B || t == L_H) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Drives one access at the current negedge and records what the DUT did.
  task automatic access(input load_store_type_e t, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rw, input int gd, input int rd, output obs_t o);
    int cyc;
    o.lat = -1; o.req_seen = 0; o.stable = 1; o.addr = '0; o.be = '0; o.wd = '0;
    o.we = 0; o.rdata = '0; o.mis = 0; o.berr = 0; o.idle_after = 0;
    req_valid_i = 1'b1; ls_type_i = t; addr_i = a; wdata_i = wd;
    mem_gnt_i = 1'($urandom); mem_rvalid_i = 1'($urandom); mem_rdata_i = $urandom;
    @(negedge clk); cyc = 1;
    req_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    addr_i = $urandom; wdata_i = $urandom;
    if (mem_req_o === 1'b1) begin
      o.req_seen = 1; o.addr = mem_addr_o; o.be = mem_be_o; o.wd = mem_wdata_o; o.we = mem_we_o;
      for (int i = 0; i <= gd; i++) begin
        if (mem_req_o !== 1'b1 || mem_addr_o !== o.addr || mem_be_o !== o.be ||
            mem_wdata_o !== o.wd || mem_we_o !== o.we) o.stable = 0;
        mem_gnt_i = (i == gd); mem_rvalid_i = 1'($urandom); mem_rdata_i = $urandom;
        @(negedge clk); cyc++;
      end
      mem_gnt_i = 1'b0;
      for (int j = 0; j <= rd; j++) begin
        if (mem_req_o !== 1'b0) o.stable = 0;
        req_valid_i = 1'($urandom);
        mem_rvalid_i = (j == rd); mem_rdata_i = (j == rd) ? rw : $urandom;
        @(negedge clk); cyc++;
      end
      mem_rvalid_i = 1'b0; req_valid_i = 1'b0;
    end
    for (int k = 0; k < 8 && o.lat < 0; k++) begin
      if (done_o === 1'b1) begin
        o.lat = cyc; o.mis = misalign_o; o.berr = bus_err_o; o.rdata = rdata_o;
      end
      @(negedge clk); cyc++;
    end
    o.idle_after = (busy_o === 1'b0 && done_o === 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_o, done_o, misalign_o, bus_err_o, mem_req_o, mem_we_o} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b required 000000",
                         {busy_o, done_o, misalign_o, bus_err_o, mem_req_o, mem_we_o});
    end
    checks++;
    if ({mem_addr_o, mem_be_o, mem_wdata_o, rdata_o} !== '0) begin
      errors++; $display("FAIL reset_data: addr %h be %b wdata %h rdata %h required all 0",
                         mem_addr_o, mem_be_o, mem_wdata_o, rdata_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_spec_vectors();
    obs_t o;
    access(S_B, 32'h103, 32'h0000_00A5, 32'h0, 0, 0, o);
    checks++;
    if ({o.addr, o.be, o.wd, o.we} !== {32'h100, 4'b1000, 32'hA5A5_A5A5, 1'b1}) begin
      errors++; $display("FAIL sb_bus: addr %h be %b wdata %h we %b required 100 1000 a5a5a5a5 1",
                         o.addr, o.be, o.wd, o.we);
    end
    checks++;
    if (o.lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d required 3", o.lat); end
    access(L_B, 32'h102, 32'h0, 32'h1280_3456, 0, 0, o);
    checks++;
    if (o.rdata !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb_sext: got %h required ffffff80", o.rdata);
    end
    access(L_BU, 32'h102, 32'h0, 32'h1280_3456, 1, 2, o);
    checks++;
    if (o.rdata !== 32'h0000_0080 || o.lat !== 6) begin
      errors++; $display("FAIL lbu_zext: got %h lat %0d required 00000080 lat 6", o.rdata, o.lat);
    end
    model_rdata = 32'h0000_0080;
  endtask

  task automatic test_misalign();
    obs_t o;
    load_store_type_e tt [3] = '{L_H, L_W, S_H};
    logic [31:0]      aa [3] = '{32'h201, 32'h202, 32'h1};
    for (int n = 0; n < 3; n++) begin
      access(tt[n], aa[n], 32'h5555_5555, 32'h0, 0, 0, o);
      checks++;
      if (o.lat !== 1 || o.mis !== 1'b1 || o.berr !== 1'b0 || o.req_seen) begin
        errors++; $display("FAIL misalign[%0d]: lat %0d mis %b berr %b req %0d required 1 1 0 0",
                           n, o.lat, o.mis, o.berr, o.req_seen);
      end
      checks++;
      if (o.rdata !== model_rdata || !o.idle_after) begin
        errors++; $display("FAIL misalign_keep[%0d]: rdata %h idle %0d required %h 1",
                           n, o.rdata, o.idle_after, model_rdata);
      end
    end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    bit req_held = 1;
    req_valid_i = 1'b1; ls_type_i = L_W; addr_i = 32'h40;
    @(negedge clk);
    req_valid_i = 1'b0; mem_gnt_i = 1'b0;
    while (done_o !== 1'b1 && cnt < TO + 20) begin
      if (mem_req_o !== 1'b1) req_held = 0;
      @(negedge clk); cnt++;
    end
    checks++;
    if (cnt !== TO || !req_held) begin
      errors++; $display("FAIL timeout_cycles: done after %0d req_held %0d required %0d 1",
                         cnt, req_held, TO);
    end
    checks++;
    if (bus_err_o !== 1'b1 || misalign_o !== 1'b0 || rdata_o !== model_rdata) begin
      errors++; $display("FAIL timeout_flags: berr %b mis %b rdata %h required 1 0 %h",
                         bus_err_o, misalign_o, rdata_o, model_rdata);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || bus_err_o !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: busy %b done %b berr %b required 0 0 0",
                         busy_o, done_o, bus_err_o);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    req_valid_i = 1'b1; ls_type_i = L_W; addr_i = 32'h20;
    @(negedge clk);
    req_valid_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    checks++;
    if ({busy_o, done_o, misalign_o, bus_err_o, mem_req_o, mem_we_o, mem_be_o,
         mem_addr_o, mem_wdata_o, rdata_o} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: busy %b done %b req %b addr %h rdata %h required 0",
                         busy_o, done_o, mem_req_o, mem_addr_o, rdata_o);
    end
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || rdata_o !== 32'h0) begin
      errors++; $display("FAIL rst_mid_late_rvalid: done %b busy %b rdata %h required 0 0 0",
                         done_o, busy_o, rdata_o);
    end
    model_rdata = '0;
    access(L_W, 32'h10, 32'h0, 32'hCAFE_F00D, 0, 0, o);
    checks++;
    if (o.lat !== 3 || o.rdata !== 32'hCAFE_F00D || o.addr !== 32'h10 || o.be !== 4'b1111) begin
      errors++; $display("FAIL rst_mid_next: lat %0d rdata %h addr %h be %b required 3 cafef00d 10 1111",
                         o.lat, o.rdata, o.addr, o.be);
    end
    model_rdata = 32'hCAFE_F00D;
  endtask

  task automatic test_back_to_back();
    obs_t o;
    access(S_H, 32'h2, 32'h0000_1234, 32'h0, 0, 0, o);
    checks++;
    if ({o.be, o.wd, o.we, o.addr} !== {4'b1100, 32'h1234_1234, 1'b1, 32'h0} || o.lat !== 3) begin
      errors++; $display("FAIL b2b_sh: be %b wdata %h we %b addr %h lat %0d required 1100 12341234 1 0 3",
                         o.be, o.wd, o.we, o.addr, o.lat);
    end
    checks++;
    if (o.rdata !== model_rdata) begin
      errors++; $display("FAIL b2b_sh_keep: rdata %h required %h", o.rdata, model_rdata);
    end
    access(L_HU, 32'h2, 32'h0, 32'h1234_ABCD, 0, 0, o);
    checks++;
    if (o.rdata !== 32'h0000_1234 || o.be !== 4'b1100 || o.we !== 1'b0) begin
      errors++; $display("FAIL b2b_lhu: rdata %h be %b we %b required 00001234 1100 0",
                         o.rdata, o.be, o.we);
    end
    model_rdata = 32'h0000_1234;
  endtask

  task automatic test_random();
    obs_t o;
    for (int n = 0; n < 60; n++) begin
      load_store_type_e t = load_store_type_e'(4'($urandom_range(1, 8)));
      logic [31:0] a = $urandom;
      logic [31:0] wd = $urandom;
      logic [31:0] rw = $urandom;
      int g = $urandom_range(0, 3);
      int r = $urandom_range(0, 3);
      bit mis = m_mis(t, a);
      bit st = m_store(t);
      int exp_lat = mis ? 1 : 3 + g + r;
      access(t, a, wd, rw, g, r, o);
      checks++;
      if (o.lat !== exp_lat || o.mis !== mis || o.berr !== 1'b0) begin
        errors++; $display("FAIL rand_done[%0d] %s a=%h: lat %0d mis %b berr %b required %0d %b 0",
                           n, t.name(), a, o.lat, o.mis, o.berr, exp_lat, mis);
      end
      checks++;
      if (o.req_seen !== !mis) begin
        errors++; $display("FAIL rand_req[%0d]: req_seen %0d required %0d", n, o.req_seen, !mis);
      end
      if (!mis) begin
        checks++;
        if (o.addr !== {a[31:2], 2'b00} || o.be !== m_be(t, a) || o.we !== st || !o.stable) begin
          errors++; $display("FAIL rand_bus[%0d] %s a=%h: addr %h be %b we %b stable %0d required %h %b %b 1",
                             n, t.name(), a, o.addr, o.be, o.we, o.stable, {a[31:2], 2'b00}, m_be(t, a), st);
        end
        if (st) begin
          checks++;
          if (o.wd !== m_wd(t, wd)) begin
            errors++; $display("FAIL rand_wdata[%0d] %s: got %h required %h", n, t.name(), o.wd, m_wd(t, wd));
          end
        end else begin
          model_rdata = m_load(t, a, rw);
        end
      end
      checks++;
      if (o.rdata !== model_rdata || !o.idle_after) begin
        errors++; $display("FAIL rand_rdata[%0d] %s a=%h w=%h: got %h idle %0d required %h 1",
                           n, t.name(), a, rw, o.rdata, o.idle_after, model_rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
